// File: rtl/mux4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_arbiter_pkg
//  Description : Shared definitions for the mux4 round-robin arbiter:
//                requester count, hold-counter width, FSM state encodings
//                and a one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux4_arbiter_pkg;

    localparam int N_REQ  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Turn a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr_pick
//  Description : Combinational round-robin picker. Searches ptr, ptr+1,
//                ptr+2, ptr+3 (mod 4) over the masked requests and returns
//                the first asserted index.
//  Ports       : req  [3:0] in  - raw request vector
//                ptr  [1:0] in  - highest-priority index
//                mask [3:0] in  - requests eligible this cycle (1 = eligible)
//                win  [1:0] out - winning index (equals ptr when none)
//                any        out - at least one eligible request
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import mux4_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [1:0]       win,
    output logic             any
);

    logic [N_REQ-1:0] w_cand;

    assign w_cand = req & mask;
    assign any    = |w_cand;

    // Walk from the farthest offset back to ptr so the closest candidate
    // to ptr is the last one written and therefore wins.
    always_comb begin
        win = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_cand[ptr + 2'(i)]) begin
                win = ptr + 2'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_arbiter
//  Description : Round-robin arbiter sharing one 4:1 mux path between four
//                requesters. Holds the grant while the owner keeps its
//                request up, with an optional hold limit that hands the
//                grant on when someone else is waiting.
//  Parameters  : MAX_HOLD - max consecutive grant cycles while another
//                           requester waits (0 = never preempt), 0..255
//  Ports       : clk          in  - system clock, rising edge
//                rst_n        in  - asynchronous active-low reset
//                req      [3:0] in  - request per requester
//                gnt      [3:0] out - one-hot grant, zero when idle
//                sel      [1:0] out - mux select, current/last owner
//                busy         out - any grant active
//                hold_cnt [7:0] out - cycles current owner has held grant
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic              c_preempt_en = (MAX_HOLD != 0);
    // hold_cnt value seen during the last permitted cycle of a held grant.
    localparam logic [HOLD_W-1:0] c_hold_last  =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [N_REQ-1:0]  r_gnt;
    logic [1:0]        r_sel;
    logic              r_busy;
    logic [HOLD_W-1:0] r_hold;

    logic [N_REQ-1:0]  w_own_oh;
    logic              w_owner_req;
    logic              w_release;
    logic              w_preempt;
    logic [1:0]        w_next_ptr;
    logic [1:0]        w_pick_ptr;
    logic [N_REQ-1:0]  w_pick_mask;
    logic [1:0]        w_win;
    logic              w_any;

    // While granted, r_sel is the owner index.
    assign w_own_oh    = onehot4(r_sel);
    assign w_owner_req = |(req & w_own_oh);
    assign w_next_ptr  = r_sel + 2'd1;

    // In GRANT the picker looks past the owner so its result is the
    // successor for both release and preempt; with the owner masked out,
    // w_any also means "somebody else is waiting".
    assign w_pick_ptr  = (r_state == ST_GRANT) ? w_next_ptr : r_ptr;
    assign w_pick_mask = (r_state == ST_GRANT) ? ~w_own_oh : {N_REQ{1'b1}};

    assign w_release = ~w_owner_req;
    assign w_preempt = c_preempt_en && (r_hold == c_hold_last)
                       && w_owner_req && w_any;

    arb_rr_pick u_pick (
        .req  (req),
        .ptr  (w_pick_ptr),
        .mask (w_pick_mask),
        .win  (w_win),
        .any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_gnt   <= '0;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // sel is left alone when nobody asks so the mux is stable.
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= onehot4(w_win);
                        r_sel   <= w_win;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_preempt) begin
                        r_ptr <= w_next_ptr;
                        if (w_any) begin
                            // Direct handover, no idle bubble.
                            r_gnt  <= onehot4(w_win);
                            r_sel  <= w_win;
                            r_hold <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_hold  <= '0;
                        end
                    end else if (r_hold != {HOLD_W{1'b1}}) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign sel      = r_sel;
    assign busy     = r_busy;
    assign hold_cnt = r_hold;

endmodule
`default_nettype wire
